dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the ARM datapath's data-memory interface: it serves the processor's read and write requests with a fixed, parameterised wait-state latency and a one-cycle acknowledge. It also contains the memory-dump sequencer, which streams every stored word out on a dedicated port when `dump` is raised. It sits between the processor's data-memory outputs (`DM_addr`, `DM_writeData`, `DM_writeEnable`, `DM_readEnable`) and the processor's read-data input. It replaces the combinational-read memory wherever wait-stated storage is modelled.

## Interface
Parameters:
- `N`, 64, data word width in bits
- `DEPTH`, 64, number of words; power of two
- `WAIT`, 2, number of wait-state cycles between accept and response; range 0..15

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present; the processor drives this as `DM_readEnable | DM_writeEnable`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  N  byte address; only bits `[log2(DEPTH)+2:3]` are used
- `req_wdata`  in  N  write data
- `rsp_valid`  out  1  one-cycle acknowledge that the request has completed
- `rsp_rdata`  out  N  read data; held until the next read response
- `dump`  in  1  dump trigger, level input, rising-edge detected
- `dump_valid`  out  1  `dump_addr` and `dump_data` are valid this cycle
- `dump_addr`  out  log2(DEPTH)  word index being dumped
- `dump_data`  out  N  contents of word `dump_addr`
- `busy`  out  1  a transaction or a dump is in progress

## Operation
State machine with states IDLE, WAITING, RESP and DUMP.

IDLE:
- If a dump is pending, go to DUMP. A dump has priority over a new request.
- Else, if `req_valid` is high, latch the word index and the write flag. Load the wait counter with `WAIT`, then go to WAITING (if `WAIT` > 0) or RESP (if `WAIT` = 0).

WAITING:
- Decrement the counter each cycle.
- When the counter reaches 1, go to RESP.
- `req_*` inputs are ignored after acceptance; only the latched index is used.

RESP:
- `rsp_valid` is high for exactly this one cycle.
- For a write: `req_wdata` is sampled and committed on the edge that enters RESP. The processor must hold `req_wdata` stable from accept until `rsp_valid`.
- For a read: `rsp_rdata` is loaded on the same edge.
- The next state is always IDLE.

DUMP:
- Emits words 0 to DEPTH-1, one per cycle, with `dump_valid` high.
- After word DEPTH-1, clears the pending flag and returns to IDLE.
- Requests arriving during a dump stall until it completes.

Boundary rules:
- **Dump trigger during a transaction:** a rising edge of `dump` seen in WAITING or RESP is latched as pending and starts at the next IDLE.
- **Retrigger during a dump:** a rising edge of `dump` while in DUMP is ignored.
- **Address wrap:** address bits above the index are ignored, so the address wraps modulo DEPTH. Bits [2:0] are ignored (no alignment check).
- **Read of an unwritten word:** returns the array's power-up content. The array is not cleared by reset.
- **Reset mid-operation:** an in-flight write that has not reached RESP is dropped, and a pending dump is cancelled.

## Timing
- Request accepted in IDLE at edge T, so `rsp_valid` is high in cycle T+1+WAIT.
- Minimum request period is WAIT+2 cycles, because RESP is always followed by an IDLE cycle.
- Dump of DEPTH words takes DEPTH cycles of `dump_valid`. It starts 1 cycle after the IDLE in which the pending flag is seen, and the pending flag is set 1 cycle after the `dump` rising edge.
- Reset values: state IDLE, `rsp_valid` 0, `rsp_rdata` 0, `dump_valid` 0, `dump_addr` 0, `dump_data` 0, `busy` 0, counter 0, pending 0, `dump` edge register 0.
- `busy` is high in WAITING, RESP and DUMP.
- All outputs are registered except `busy`, which decodes the state.

## Structure
- Package `dmem_pkg`: the state enum (IDLE, WAITING, RESP, DUMP) and the default `N`, `DEPTH` and `WAIT` constants.
- Sub-module `dmem_array`: a DEPTH×N synchronous-write array with two read ports (transaction and dump) and no reset. The FSM, counter and dump sequencer stay in the top module.

## Test plan
- **Write then read, WAIT=2:** write 0xDEADBEEF to byte address 0x18 → `rsp_valid` in cycle T+3. A read of 0x18 then returns 0xDEADBEEF with `rsp_valid` at T'+3.
- **WAIT=0, back-to-back:** write word 5, then read word 5 → each `rsp_valid` one cycle after accept, with one IDLE cycle between. The read returns the written value.
- **Address wrap, DEPTH=64:** write 0x1 to byte address 0x200 + 0x08 → a read of 0x08 returns 0x1.
- **Dump:** fill word i with i*3, then pulse `dump` → 64 consecutive cycles with `dump_valid`=1, `dump_addr`=0..63 and `dump_data`=i*3, and `busy`=1 throughout.
- **Dump raised during WAITING:** the write still completes (`rsp_valid` once), then the dump starts at the next IDLE. A request held high during the dump is accepted only after `dump_addr`=63.
- **Reset asserted during WAITING of a write to word 7:** all outputs return to 0 asynchronously and word 7 is unchanged. A request after reset release behaves normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data-memory responder:
// controller state encoding and default geometry/latency constants.
package dmem_pkg;

    localparam int DEF_N     = 64;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_WAIT  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        RESP    = 2'd2,
        DUMP    = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x N storage: one synchronous write port, two asynchronous read
// ports (transaction side and dump side). Deliberately not reset, so a
// read of a never-written word returns whatever the array powered up with.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_widx,
    input  logic [N-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_ridx,
    output logic [N-1:0]             o_rdata,
    input  logic [$clog2(DEPTH)-1:0] i_didx,
    output logic [N-1:0]             o_ddata
);

    logic [N-1:0] r_mem [DEPTH];

    // Commit a write word on the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];
    assign o_ddata = r_mem[i_didx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one read/write request at a
// time, waits WAIT cycles, then acknowledges with a one-cycle rsp_valid.
// Also sequences a full memory dump when the dump input rises.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    parameter int WAIT  = DEF_WAIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [N-1:0]             req_addr,
    input  logic [N-1:0]             req_wdata,
    output logic                     rsp_valid,
    output logic [N-1:0]             rsp_rdata,
    input  logic                     dump,
    output logic                     dump_valid,
    output logic [$clog2(DEPTH)-1:0] dump_addr,
    output logic [N-1:0]             dump_data,
    output logic                     busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [3:0]    WAIT_CNT = 4'(WAIT);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_write;
    logic            r_dump_q;
    logic            r_pending;
    logic            r_rsp_valid;
    logic [N-1:0]    r_rsp_rdata;
    logic            r_dump_valid;
    logic [AW-1:0]   r_dump_addr;
    logic [N-1:0]    r_dump_data;

    logic [AW-1:0]   w_req_idx;
    logic            w_dump_rise;
    logic            w_accept;
    logic            w_enter_resp;
    logic            w_cur_write;
    logic [AW-1:0]   w_cur_idx;
    logic            w_mem_we;
    logic [N-1:0]    w_rd_data;
    logic [AW-1:0]   w_dump_rd_idx;
    logic [N-1:0]    w_dump_rd_data;
    logic            w_unused_addr;

    // Word index: byte-offset bits are dropped and upper bits wrap modulo DEPTH.
    assign w_req_idx     = req_addr[AW+2:3];
    assign w_unused_addr = ^{req_addr[N-1:AW+3], req_addr[2:0]};
    assign w_dump_rise   = dump & ~r_dump_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a pending dump wins over a new request in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_next = DUMP;
                end else if (req_valid) begin
                    w_next = (WAIT == 0) ? RESP : WAITING;
                end
            end
            WAITING: begin
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            DUMP: begin
                if (r_dump_addr == LAST_IDX) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Control decode; with WAIT=0 the request goes to RESP straight from
    // IDLE, so the live request fields are used instead of the latched ones.
    always_comb begin
        busy         = (r_state != IDLE);
        w_accept     = (r_state == IDLE) && !r_pending && req_valid;
        w_enter_resp = (w_next == RESP);
        w_cur_write  = (r_state == IDLE) ? req_write : r_write;
        w_cur_idx    = (r_state == IDLE) ? w_req_idx : r_idx;
        w_mem_we     = w_enter_resp && w_cur_write;
    end

    // Latch the request at accept and count down the wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= WAIT_CNT;
            r_idx   <= w_req_idx;
            r_write <= req_write;
        end else if (r_state == WAITING) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Dump trigger edge detect; a rise during DUMP is ignored, otherwise it
    // stays pending until the dump finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dump_q  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_dump_q <= dump;
            if (r_state == DUMP && w_next == IDLE) begin
                r_pending <= 1'b0;
            end else if (w_dump_rise && r_state != DUMP) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Response acknowledge and read data; rdata holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_enter_resp;
            if (w_enter_resp && !w_cur_write) begin
                r_rsp_rdata <= w_rd_data;
            end
        end
    end

    // The dump port reads ahead so each registered word lines up with a DUMP cycle.
    assign w_dump_rd_idx = (r_state == DUMP) ? (r_dump_addr + AW'(1)) : '0;

    // Dump sequencer: word 0 is loaded on entry, then one word per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
        end else if (r_state == IDLE && w_next == DUMP) begin
            r_dump_valid <= 1'b1;
            r_dump_addr  <= '0;
            r_dump_data  <= w_dump_rd_data;
        end else if (r_state == DUMP) begin
            if (r_dump_addr == LAST_IDX) begin
                r_dump_valid <= 1'b0;
            end else begin
                r_dump_addr  <= r_dump_addr + AW'(1);
                r_dump_data  <= w_dump_rd_data;
            end
        end
    end

    dmem_array #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_widx  (w_cur_idx),
        .i_wdata (req_wdata),
        .i_ridx  (w_cur_idx),
        .o_rdata (w_rd_data),
        .i_didx  (w_dump_rd_idx),
        .o_ddata (w_dump_rd_data)
    );

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT=2 instance carries most of
// the traffic and dumps, a WAIT=0 instance covers back-to-back timing.
module tb_dmem_responder;

    localparam int N     = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int WT    = 2;

    typedef struct {
        int           cyc;
        bit           rel;
        logic [N-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_valid0 = 1'b0;
    logic          req_write = 1'b0;
    logic [N-1:0]  req_addr = '0;
    logic [N-1:0]  req_wdata = '0;
    logic          dump = 1'b0;
    logic          dump0 = 1'b0;

    logic          rsp_valid, dump_valid, busy;
    logic [N-1:0]  rsp_rdata, dump_data;
    logic [AW-1:0] dump_addr;
    logic          rsp_valid0, dump_valid0, busy0;
    logic [N-1:0]  rsp_rdata0, dump_data0;
    logic [AW-1:0] dump_addr0;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rsp = 0;
    int n_rsp0 = 0;
    int n_dump = 0;
    int first_dump_cyc = -1;
    int last_dump_cyc = -1;

    exp_t         q[$];
    exp_t         q0[$];
    logic [N-1:0] dq[$];
    logic [N-1:0] mem_m [DEPTH];
    logic [N-1:0] last_rd = '0;

    dmem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(WT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .dump(dump), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy)
    );

    dmem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .dump(dump0), .dump_valid(dump_valid0),
        .dump_addr(dump_addr0), .dump_data(dump_data0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(input int target, input string name);
        int k = 0;
        while (n_rsp < target && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        if (n_rsp < target) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout: got %0d responses expected %0d", name, n_rsp, target);
        end
    endtask

    task automatic wait_dump(input int target, input string name);
        int k = 0;
        while (n_dump < target && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        if (n_dump < target) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout: got %0d dump words expected %0d", name, n_dump, target);
        end
    endtask

    // One complete request on the WAIT=2 instance, waiting for its response.
    task automatic issue(input bit wr, input logic [N-1:0] addr, input logic [N-1:0] data);
        exp_t e;
        int   idx;
        int   tgt;
        @(negedge clk);
        idx = int'(addr[8:3]);
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_valid = 1'b1;
        if (wr) mem_m[idx] = data;
        else    last_rd = mem_m[idx];
        e.cyc   = cyc + 1 + WT;
        e.rel   = 1'b0;
        e.rdata = last_rd;
        q.push_back(e);
        tgt = n_rsp + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(tgt, "issue");
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_valid"},  64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"},  rsp_rdata, 64'd0);
        chk({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
        chk({tag, "_dump_addr"},  64'(dump_addr), 64'd0);
        chk({tag, "_dump_data"},  dump_data, 64'd0);
        chk({tag, "_busy"},       64'(busy), 64'd0);
    endtask

    // Monitor for the WAIT=2 instance: responses and dump words.
    always @(negedge clk) begin : mon
        exp_t         e;
        int           ecyc;
        logic [N-1:0] d;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                ecyc = e.rel ? (last_dump_cyc + 2 + WT) : e.cyc;
                chk("rsp_cycle", 64'(cyc), 64'(ecyc));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
            n_rsp++;
        end
        if (dump_valid) begin
            chk("dump_busy", 64'(busy), 64'd1);
            chk("dump_addr", 64'(dump_addr), 64'(n_dump % DEPTH));
            if (dq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL dump_unexpected: got dump word at cycle %0d expected none", cyc);
            end else begin
                d = dq.pop_front();
                chk("dump_data", dump_data, d);
            end
            if (dump_addr == 6'd0)  first_dump_cyc = cyc;
            if (dump_addr == 6'd63) last_dump_cyc = cyc;
            n_dump++;
        end
    end

    // Monitor for the WAIT=0 instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rsp_valid0) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp0_unexpected: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                chk("rsp0_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp0_rdata", rsp_rdata0, e.rdata);
            end
            n_rsp0++;
        end
    end

    initial begin : stim
        int acc;
        int tgt;
        int nb;
        int dcyc;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b1;

        // WAIT=0 back-to-back: write word 5 then read it
        @(negedge clk);
        req_write  = 1'b1;
        req_addr   = 64'h28;
        req_wdata  = 64'h1234_5678_9ABC_DEF0;
        req_valid0 = 1'b1;
        acc = cyc + 1;
        q0.push_back('{acc, 1'b0, 64'h0});
        q0.push_back('{acc + 2, 1'b0, 64'h1234_5678_9ABC_DEF0});
        @(posedge clk); #1;
        req_write = 1'b0;
        chk("w0_busy_resp", 64'(busy0), 64'd1);
        @(posedge clk); #1;
        chk("w0_idle_gap", 64'(busy0), 64'd0);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w0_queue_empty", 64'(q0.size()), 64'd0);
        chk("w0_rsp_count", 64'(n_rsp0), 64'd2);

        // WAIT=2 write then read at byte address 0x18
        issue(1'b1, 64'h18, 64'hDEAD_BEEF);
        issue(1'b0, 64'h18, 64'h0);
        // Low address bits ignored
        issue(1'b0, 64'h1F, 64'h0);
        // Address wrap: 0x208 aliases 0x08
        issue(1'b1, 64'h208, 64'h1);
        issue(1'b0, 64'h08, 64'h0);

        // Fill word i with i*3
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 64'(i) << 3, 64'(i * 3));
        end

        // Dump with a retrigger in the middle that must be ignored
        for (int i = 0; i < DEPTH; i++) dq.push_back(mem_m[i]);
        nb = n_dump;
        @(negedge clk);
        dump = 1'b1;
        dcyc = cyc;
        @(negedge clk);
        @(negedge clk);
        dump = 1'b0;
        wait_dump(nb + 10, "dump_mid");
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        wait_dump(nb + DEPTH, "dump_all");
        chk("dump_start_cycle", 64'(first_dump_cyc), 64'(dcyc + 2));
        repeat (6) @(negedge clk);
        #1;
        chk("dump_done_busy", 64'(busy), 64'd0);
        chk("dump_no_retrigger", 64'(n_dump - nb), 64'(DEPTH));

        // Dump raised during WAITING of a write to word 10
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 64'h50;
        req_wdata = 64'h55;
        req_valid = 1'b1;
        mem_m[10] = 64'h55;
        acc = cyc + 1;
        q.push_back('{acc + WT, 1'b0, last_rd});
        tgt = n_rsp + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) dq.push_back(mem_m[i]);
        nb = n_dump;
        @(negedge clk);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        wait_rsp(tgt, "wr_during_dump");
        wait_dump(nb + 5, "dump2_start");
        chk("dump2_start_cycle", 64'(first_dump_cyc), 64'(acc + 4));
        // Read of word 10 held high during the dump stalls until it ends
        req_write = 1'b0;
        req_addr  = 64'h50;
        req_valid = 1'b1;
        last_rd   = mem_m[10];
        e.cyc = 0;
        e.rel = 1'b1;
        e.rdata = 64'h55;
        q.push_back(e);
        tgt = n_rsp + 1;
        wait_dump(nb + DEPTH, "dump2_all");
        chk("stall_no_early_rsp", 64'(n_rsp), 64'(tgt - 1));
        @(posedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(tgt, "stalled_read");

        // Reset during WAITING of a write to word 7
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 64'h38;
        req_wdata = 64'hBAD;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        last_rd = '0;
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 64'h38, 64'h0);
        chk("word7_kept", last_rd, 64'd21);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_dump_queue_empty", 64'(dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
